icache_direct: RTL and testbench

Direct-mapped, read-only instruction cache between the IF stage and instruction memory. It replaces the pass-through wiring that currently connects `Instr_address_2IC`/`Instr1_fIC` directly to the memory ports, and it drives `iBlkRead`. Hits return the instruction combinationally in the same cycle. Misses fetch one 256-bit block (8 words) from memory through the block-read handshake, then replay the lookup.

---
 rtl/icache_direct.sv | 111 +++++++++++
 tb/tb_icache_direct.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache: 0-cycle hits, 256-bit block refill on miss.
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
module icache_direct #(
    parameter int INDEX_BITS = 5
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic [31:0]  Instr_address_2IC,
    output logic [31:0]  Instr1_fIC,
    output logic         Instr1_valid_fIC,
    input  logic         Flush_2IC,
    output logic [31:0]  Instr_address_2IM,
    output logic         iBlkRead,
    input  logic [255:0] block_read_fIM,
    input  logic         block_read_fIM_valid
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]  ICache_hits,
    output logic [31:0]  ICache_misses
`endif
);

    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = 27 - INDEX_BITS;

    typedef enum logic {IDLE, FILL} state_t;

    state_t                state_q, state_d;
    logic [LINES-1:0]      valid_q;
    logic [TAG_BITS-1:0]   tag_q  [LINES];
    logic [255:0]          data_q [LINES];
    logic [26:0]           miss_addr_q;

    logic [INDEX_BITS-1:0] idx;
    logic [TAG_BITS-1:0]   addr_tag;
    logic [2:0]            word_sel;
    logic [255:0]          rd_line;
    logic [31:0]           line_word;
    logic [INDEX_BITS-1:0] fill_idx;
    logic [TAG_BITS-1:0]   fill_tag;
    logic                  hit;
    logic                  fill_done;
    logic                  unused_addr_bits;

    assign idx              = Instr_address_2IC[INDEX_BITS+4:5];
    assign addr_tag         = Instr_address_2IC[31:INDEX_BITS+5];
    assign word_sel         = Instr_address_2IC[4:2];
    assign unused_addr_bits = ^Instr_address_2IC[1:0];
    assign rd_line          = data_q[idx];
    assign line_word        = rd_line[{word_sel, 5'b0} +: 32];
    assign fill_idx         = miss_addr_q[INDEX_BITS-1:0];
    assign fill_tag         = miss_addr_q[26:INDEX_BITS];
    assign Instr_address_2IM = {miss_addr_q, 5'b0};

    always_comb begin
        state_d   = state_q;
        hit       = 1'b0;
        iBlkRead  = 1'b0;
        fill_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                hit = valid_q[idx] && (tag_q[idx] == addr_tag);
                if (!hit) state_d = FILL;
            end
            FILL: begin
                iBlkRead = 1'b1;
                if (block_read_fIM_valid) begin
                    fill_done = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        Instr1_valid_fIC = hit;
        Instr1_fIC       = hit ? line_word : '0;
    end

    // Flush takes priority over a completing fill: the line is written but stays invalid.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= IDLE;
            miss_addr_q <= '0;
            valid_q     <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && !hit) miss_addr_q <= Instr_address_2IC[31:5];
            if (Flush_2IC)      valid_q           <= '0;
            else if (fill_done) valid_q[fill_idx] <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (fill_done) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= block_read_fIM;
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            ICache_hits   <= '0;
            ICache_misses <= '0;
        end else if (state_q == IDLE) begin
            if (hit) ICache_hits   <= ICache_hits + 32'd1;
            else     ICache_misses <= ICache_misses + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_icache_direct.sv
// Bench for icache_direct: directed scenarios plus randomized fetch/flush/memory traffic
// checked every cycle against a line-level model of the cache contents.
module tb_icache_direct;

    localparam int IB = 5;
    localparam int NL = 1 << IB;

    logic         CLK;
    logic         RESET;
    logic [31:0]  addr;
    logic [31:0]  Instr1_fIC;
    logic         Instr1_valid_fIC;
    logic         flush;
    logic [31:0]  Instr_address_2IM;
    logic         iBlkRead;
    logic [255:0] blk;
    logic         mv;
`ifdef ICACHE_STATS_EN
    logic [31:0]  ICache_hits;
    logic [31:0]  ICache_misses;
`endif

    icache_direct #(.INDEX_BITS(IB)) dut (
        .CLK                  (CLK),
        .RESET                (RESET),
        .Instr_address_2IC    (addr),
        .Instr1_fIC           (Instr1_fIC),
        .Instr1_valid_fIC     (Instr1_valid_fIC),
        .Flush_2IC            (flush),
        .Instr_address_2IM    (Instr_address_2IM),
        .iBlkRead             (iBlkRead),
        .block_read_fIM       (blk),
        .block_read_fIM_valid (mv)
`ifdef ICACHE_STATS_EN
        ,
        .ICache_hits          (ICache_hits),
        .ICache_misses        (ICache_misses)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    // Model: which line-aligned address each set holds, plus the outstanding request.
    bit          m_valid [NL];
    logic [31:0] m_line  [NL];
    bit          m_fill;
    logic [31:0] m_req;
    logic [31:0] m_hits, m_misses;
    int          lat;
    int          fixed_lat = 2;
    bit          noise     = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0040_0000) return 32'h2402_0004;
        return {a[15:0], a[31:16]} ^ 32'hC3A5_9617;
    endfunction

    function automatic logic [255:0] make_block(input logic [31:0] line);
        logic [255:0] b;
        for (int w = 0; w < 8; w++) b[32*w +: 32] = mem_word(line + 32'(4 * w));
        return b;
    endfunction

    function automatic int set_of(input logic [31:0] a);
        return int'((a >> 5) % NL);
    endfunction

    function automatic logic [31:0] line_of(input logic [31:0] a);
        return {a[31:5], 5'b0};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
        m_fill   = 1'b0;
        m_req    = '0;
        m_hits   = '0;
        m_misses = '0;
    endtask

    task automatic step_model();
        int  s;
        bit  h;
        if (!RESET) return;
        s = set_of(addr);
        if (!m_fill) begin
            h = m_valid[s] && (m_line[s] == line_of(addr));
            if (h) m_hits++;
            else begin
                m_misses++;
                m_fill = 1'b1;
                m_req  = line_of(addr);
                lat    = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 4));
            end
            if (flush) for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
        end else begin
            if (flush) for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
            if (mv) begin
                m_line[set_of(m_req)]  = m_req;
                m_valid[set_of(m_req)] = !flush;
                m_fill = 1'b0;
            end
        end
    endtask

    task automatic drive_mem();
        logic [255:0] junk;
        for (int w = 0; w < 8; w++) junk[32*w +: 32] = $urandom;
        if (m_fill) begin
            if (lat <= 0) begin
                mv  = 1'b1;
                blk = make_block(m_req);
            end else begin
                mv  = 1'b0;
                blk = junk;
                lat--;
            end
        end else begin
            mv  = noise && ($urandom_range(0, 7) == 0);
            blk = junk;
        end
    endtask

    // Leaves the bench 4 time units after the edge with this cycle's inputs applied.
    task automatic tick(input logic [31:0] a, input logic f);
        @(posedge CLK);
        step_model();
        #1;
        addr  = a;
        flush = f;
        drive_mem();
        #3;
    endtask

    task automatic fetch(input logic [31:0] a, output int n);
        n = 0;
        do begin
            tick(a, 1'b0);
            n++;
        end while (!Instr1_valid_fIC && n < 40);
        if (!Instr1_valid_fIC) chk("fetch_timeout", 32'(Instr1_valid_fIC), 32'd1);
    endtask

    always @(negedge CLK) begin
        if (chk_en) begin
            int          s;
            logic        eh;
            s  = set_of(addr);
            eh = !m_fill && m_valid[s] && (m_line[s] == line_of(addr));
            chk("valid", 32'(Instr1_valid_fIC), 32'(eh));
            chk("instr", Instr1_fIC, eh ? mem_word({addr[31:2], 2'b0}) : 32'd0);
            chk("blkread", 32'(iBlkRead), 32'(m_fill));
            chk("im_addr", Instr_address_2IM, m_req);
`ifdef ICACHE_STATS_EN
            chk("hits_cnt", ICache_hits, m_hits);
            chk("miss_cnt", ICache_misses, m_misses);
`endif
        end
    end

    initial begin
        int n;
        logic [31:0] a;
        RESET = 1'b0;
        addr  = '0;
        flush = 1'b0;
        mv    = 1'b0;
        blk   = '0;
        model_reset();
        chk_en = 1'b1;
        tick(32'h0, 1'b0);
        tick(32'h0, 1'b0);
        chk("rst_valid", 32'(Instr1_valid_fIC), 32'd0);
        chk("rst_instr", Instr1_fIC, 32'd0);
        chk("rst_blkread", 32'(iBlkRead), 32'd0);
        chk("rst_im_addr", Instr_address_2IM, 32'd0);

        // Cold miss, memory answers in the third FILL cycle.
        fixed_lat = 2;
        addr  = 32'h0040_0000;
        RESET = 1'b1;
        #1;
        chk("t1_miss", 32'(Instr1_valid_fIC), 32'd0);
        tick(32'h0040_0000, 1'b0);
        chk("t1_req", 32'(iBlkRead), 32'd1);
        chk("t1_req_addr", Instr_address_2IM, 32'h0040_0000);
        chk("t1_wait", 32'(Instr1_valid_fIC), 32'd0);
        tick(32'h0040_0000, 1'b0);
        tick(32'h0040_0000, 1'b0);
        tick(32'h0040_0000, 1'b0);
        chk("t1_hit", 32'(Instr1_valid_fIC), 32'd1);
        chk("t1_data", Instr1_fIC, 32'h2402_0004);
        chk("t1_blk_low", 32'(iBlkRead), 32'd0);

        for (int w = 1; w < 8; w++) begin
            tick(32'h0040_0000 + 32'(4 * w), 1'b0);
            chk("t2_hit", 32'(Instr1_valid_fIC), 32'd1);
            chk("t2_data", Instr1_fIC, mem_word(32'h0040_0000 + 32'(4 * w)));
            chk("t2_noblk", 32'(iBlkRead), 32'd0);
        end

`ifdef ICACHE_STATS_EN
        tick(32'h0040_0000, 1'b0);
        chk("t6_hits", ICache_hits, 32'd8);
        chk("t6_misses", ICache_misses, 32'd1);
`endif

        // Conflict eviction: same set, alternating tags.
        fixed_lat = 0;
        tick(32'h0040_0000, 1'b1);
        fetch(32'h0040_0000, n); chk("t3_cycles_a", 32'(n), 32'd3);
        fetch(32'h0040_0400, n); chk("t3_cycles_b", 32'(n), 32'd3);
        fetch(32'h0040_0000, n); chk("t3_cycles_c", 32'(n), 32'd3);
        chk("t3_data", Instr1_fIC, 32'h2402_0004);

        // Redirect during FILL.
        fixed_lat = 3;
        tick(32'h0040_0040, 1'b0);
        for (int c = 0; c < 4; c++) begin
            tick(32'h0040_0080, 1'b0);
            chk("t4_hold_addr", Instr_address_2IM, 32'h0040_0040);
            chk("t4_hold_req", 32'(iBlkRead), 32'd1);
        end
        tick(32'h0040_0080, 1'b0);
        chk("t4_second_miss", 32'(Instr1_valid_fIC), 32'd0);
        tick(32'h0040_0080, 1'b0);
        chk("t4_second_addr", Instr_address_2IM, 32'h0040_0080);
        fetch(32'h0040_0080, n);
        tick(32'h0040_0044, 1'b0);
        chk("t4_first_installed", 32'(Instr1_valid_fIC), 32'd1);

        // Flush in the fill-completion cycle.
        fixed_lat = 0;
        tick(32'h0040_0100, 1'b0);
        tick(32'h0040_0100, 1'b1);
        chk("t5_flush_cycle_req", 32'(iBlkRead), 32'd1);
        tick(32'h0040_0100, 1'b0);
        chk("t5_after_flush_miss", 32'(Instr1_valid_fIC), 32'd0);
        fetch(32'h0040_0100, n);

        // Reset in the middle of a FILL.
        fixed_lat = 4;
        tick(32'h0040_0200, 1'b0);
        tick(32'h0040_0200, 1'b0);
        chk("t5_fill_req", 32'(iBlkRead), 32'd1);
        RESET = 1'b0;
        model_reset();
        #1;
        chk("t5_rst_blk", 32'(iBlkRead), 32'd0);
        chk("t5_rst_addr", Instr_address_2IM, 32'd0);
        tick(32'h0040_0004, 1'b0);
        addr  = 32'h0040_0004;
        RESET = 1'b1;
        #1;
        chk("t5_lines_invalid", 32'(Instr1_valid_fIC), 32'd0);
        fixed_lat = 0;
        fetch(32'h0040_0004, n);
        chk("t5_refill_data", Instr1_fIC, mem_word(32'h0040_0004));

        // Randomized traffic over three tags sharing sets.
        fixed_lat = -1;
        noise     = 1'b1;
        a = 32'h0040_0000;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 9) < 3)
                a = 32'h0040_0000 + (32'($urandom_range(0, 2)) << 10)
                    + (32'($urandom_range(0, 7)) << 5) + 32'($urandom_range(0, 31));
            tick(a, $urandom_range(0, 31) == 0);
        end
        noise = 1'b0;
        tick(a, 1'b0);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
